scoreboard_regfile: RTL and testbench

//   Parametrised register file for the pipelined core: XLEN x NREGS storage, NREAD combinational

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_read_port.sv | 35 +++
 rtl/scoreboard_regfile.sv | 78 +++++++
 tb/tb_scoreboard_regfile.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and default sizes for decode, issue and writeback.
package regfile_pkg;

    localparam int REGFILE_XLEN  = 32;
    localparam int REGFILE_NREGS = 32;

    typedef logic [$clog2(REGFILE_NREGS)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: state lookup with zero-register and writeback bypass muxing.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = REGFILE_XLEN,
    parameter int NREGS    = REGFILE_NREGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NREGS)
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic [NREGS*XLEN-1:0] mem_flat,
    input  logic [NREGS-1:0]      busy,
    input  logic                  write_enable,
    input  logic [ADDR_W-1:0]     write_addr,
    input  logic [XLEN-1:0]       write_value,
    output logic [XLEN-1:0]       value,
    output logic                  pending
);

    // Priority low to high: stored state, same-cycle writeback, hardwired zero.
    always_comb begin
        value   = mem_flat[int'(addr)*XLEN +: XLEN];
        pending = busy[addr];
        if (BYPASS != 0 && write_enable && write_addr == addr) begin
            value   = write_value;
            pending = 1'b0;
        end
        if (ZERO_REG != 0 && addr == '0) begin
            value   = '0;
            pending = 1'b0;
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register busy scoreboard: issue reserves a destination,
// writeback writes it and clears busy; decode reads data plus pending flags.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int XLEN     = REGFILE_XLEN,
    parameter int NREGS    = REGFILE_NREGS,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NREGS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] addressForReading,
    output logic [NREAD*XLEN-1:0]   values,
    output logic [NREAD-1:0]        pending,
    input  logic                    writeEnable,
    input  logic [ADDR_W-1:0]       addressForWriting,
    input  logic [XLEN-1:0]         valueForWriting,
    input  logic                    reserveEnable,
    input  logic [ADDR_W-1:0]       addressForReserving,
    output logic [NREGS-1:0]        busyMask
);

    logic [XLEN-1:0]       mem [NREGS];
    logic [NREGS*XLEN-1:0] mem_flat;
    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busy_next;
    logic                  write_ok;
    logic                  reserve_ok;

    assign write_ok   = writeEnable   && !(ZERO_REG != 0 && addressForWriting   == '0);
    assign reserve_ok = reserveEnable && !(ZERO_REG != 0 && addressForReserving == '0);

    // Reserve is applied after the writeback clear so a same-address pair ends busy.
    always_comb begin
        busy_next = busy;
        if (write_ok)   busy_next[addressForWriting]   = 1'b0;
        if (reserve_ok) busy_next[addressForReserving] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            if (write_ok) mem[addressForWriting] <= valueForWriting;
            busy <= busy_next;
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int i = 0; i < NREGS; i++) mem_flat[i*XLEN +: XLEN] = mem[i];
    end

    assign busyMask = busy;

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        regfile_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .addr         (addressForReading[k*ADDR_W +: ADDR_W]),
            .mem_flat     (mem_flat),
            .busy         (busy),
            .write_enable (writeEnable),
            .write_addr   (addressForWriting),
            .write_value  (valueForWriting),
            .value        (values[k*XLEN +: XLEN]),
            .pending      (pending[k])
        );
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: a bypassing and a non-bypassing instance
// share stimulus; expectations are queued by the driver and checked by a monitor.
module tb_scoreboard_regfile;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int ADDR_W = 5;

    // Observation selectors: base + port index.
    localparam int S_VAL    = 0;
    localparam int S_PEND   = 10;
    localparam int S_BUSY   = 20;
    localparam int S_NB_VAL = 30;
    localparam int S_NB_PND = 40;
    localparam int S_NB_BSY = 50;

    logic                    clock;
    logic                    reset;
    logic [NREAD*ADDR_W-1:0] addressForReading;
    logic                    writeEnable;
    logic [ADDR_W-1:0]       addressForWriting;
    logic [XLEN-1:0]         valueForWriting;
    logic                    reserveEnable;
    logic [ADDR_W-1:0]       addressForReserving;
    logic [NREAD*XLEN-1:0]   values,   nb_values;
    logic [NREAD-1:0]        pending,  nb_pending;
    logic [NREGS-1:0]        busyMask, nb_busyMask;

    scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1), .ZERO_REG(1)) dut (
        .clock               (clock),
        .reset               (reset),
        .addressForReading   (addressForReading),
        .values              (values),
        .pending             (pending),
        .writeEnable         (writeEnable),
        .addressForWriting   (addressForWriting),
        .valueForWriting     (valueForWriting),
        .reserveEnable       (reserveEnable),
        .addressForReserving (addressForReserving),
        .busyMask            (busyMask)
    );

    scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clock               (clock),
        .reset               (reset),
        .addressForReading   (addressForReading),
        .values              (nb_values),
        .pending             (nb_pending),
        .writeEnable         (writeEnable),
        .addressForWriting   (addressForWriting),
        .valueForWriting     (valueForWriting),
        .reserveEnable       (reserveEnable),
        .addressForReserving (addressForReserving),
        .busyMask            (nb_busyMask)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, stimulus did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    int          check_count = 0;
    int          pass_count  = 0;

    function automatic logic [63:0] observe(input int sel);
        logic [63:0] r;
        int k;
        k = sel % 10;
        r = '0;
        case (sel - k)
            S_VAL:    r = 64'(values[k*XLEN +: XLEN]);
            S_PEND:   r = 64'(pending[k]);
            S_BUSY:   r = 64'(busyMask);
            S_NB_VAL: r = 64'(nb_values[k*XLEN +: XLEN]);
            S_NB_PND: r = 64'(nb_pending[k]);
            S_NB_BSY: r = 64'(nb_busyMask);
            default:  r = '1;
        endcase
        return r;
    endfunction

    // Monitor: outputs are combinational, so every queued expectation is due at the next falling edge.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            logic [63:0] e, a;
            int          s;
            string       n;
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = name_q.pop_front();
            a = observe(s);
            check_count++;
            if (a === e) pass_count++;
            else $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_out(input int sel, input logic [63:0] e, input string n);
        sel_q.push_back(sel);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic expect_reads(input logic [31:0] v, input logic p, input logic [31:0] nbv,
                                input logic nbp, input string n);
        for (int k = 0; k < NREAD; k++) begin
            expect_out(S_VAL + k,    64'(v),   $sformatf("%s val p%0d", n, k));
            expect_out(S_PEND + k,   64'(p),   $sformatf("%s pend p%0d", n, k));
            expect_out(S_NB_VAL + k, 64'(nbv), $sformatf("%s nb val p%0d", n, k));
            expect_out(S_NB_PND + k, 64'(nbp), $sformatf("%s nb pend p%0d", n, k));
        end
    endtask

    task automatic expect_busy(input logic [31:0] m, input string n);
        expect_out(S_BUSY,   64'(m), $sformatf("%s busy", n));
        expect_out(S_NB_BSY, 64'(m), $sformatf("%s nb busy", n));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        writeEnable   = 1'b0;
        reserveEnable = 1'b0;
        reset         = 1'b0;
    endtask

    task automatic set_reads(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        addressForReading = {a1, a0};
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] v);
        writeEnable       = 1'b1;
        addressForWriting = a;
        valueForWriting   = v;
    endtask

    task automatic do_reserve(input logic [ADDR_W-1:0] a);
        reserveEnable       = 1'b1;
        addressForReserving = a;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        writeEnable = 1'b0; reserveEnable = 1'b0;
        addressForWriting = '0; valueForWriting = '0; addressForReserving = '0;
        set_reads(5'd0, 5'd0);
        step(); step();
        idle();

        // 1: write x5, then reset with a write and reserve pending; both dropped.
        do_write(5'd5, 32'hDEAD);
        step();
        idle();
        set_reads(5'd5, 5'd5);
        expect_reads(32'hDEAD, 1'b0, 32'hDEAD, 1'b0, "x5 before reset");
        step();
        reset = 1'b1;
        do_write(5'd5, 32'hBEEF);
        do_reserve(5'd9);
        step();
        idle();
        set_reads(5'd5, 5'd9);
        expect_out(S_VAL + 0, 64'h0, "x5 after reset");
        expect_out(S_VAL + 1, 64'h0, "x9 after reset");
        expect_out(S_NB_VAL + 0, 64'h0, "nb x5 after reset");
        expect_busy(32'h0, "after reset");
        step();

        // 2: fill registers; x0 write is ignored and reads zero even while being written.
        for (int i = 0; i < NREGS; i++) begin
            do_write(ADDR_W'(i), 32'(i + 10));
            if (i == 0) begin
                set_reads(5'd0, 5'd0);
                expect_out(S_VAL + 0, 64'h0, "x0 bypass write");
                expect_out(S_PEND + 0, 64'h0, "x0 bypass pend");
            end
            step();
        end
        idle();
        set_reads(5'd0, 5'd0);
        expect_reads(32'h0, 1'b0, 32'h0, 1'b0, "x0 read");
        step();
        set_reads(5'd17, 5'd17);
        expect_reads(32'd27, 1'b0, 32'd27, 1'b0, "x17 read");
        step();
        set_reads(5'd31, 5'd1);
        expect_out(S_VAL + 0, 64'd41, "x31 read");
        expect_out(S_VAL + 1, 64'd11, "x1 read");
        step();

        // 3: same-cycle bypass vs. stored value.
        do_write(5'd7, 32'h1234);
        set_reads(5'd7, 5'd7);
        expect_reads(32'h1234, 1'b0, 32'd17, 1'b0, "x7 same cycle");
        step();
        idle();
        expect_reads(32'h1234, 1'b0, 32'h1234, 1'b0, "x7 next cycle");
        step();

        // 4: reserve then writeback of x3.
        do_reserve(5'd3);
        set_reads(5'd3, 5'd3);
        expect_reads(32'd13, 1'b0, 32'd13, 1'b0, "x3 during reserve");
        step();
        idle();
        expect_busy(32'h8, "x3 reserved");
        expect_reads(32'd13, 1'b1, 32'd13, 1'b1, "x3 reserved");
        step();
        do_write(5'd3, 32'h55);
        expect_reads(32'h55, 1'b0, 32'd13, 1'b1, "x3 writeback cycle");
        step();
        idle();
        expect_busy(32'h0, "x3 written");
        expect_reads(32'h55, 1'b0, 32'h55, 1'b0, "x3 written");
        step();

        // 5: same-address reserve+write ends busy; different addresses act independently.
        do_reserve(5'd4);
        do_write(5'd4, 32'h99);
        step();
        idle();
        set_reads(5'd4, 5'd4);
        expect_busy(32'h10, "x4 res+wr");
        expect_reads(32'h99, 1'b1, 32'h99, 1'b1, "x4 res+wr");
        step();
        do_reserve(5'd6);
        do_write(5'd4, 32'h77);
        step();
        idle();
        set_reads(5'd4, 5'd6);
        expect_busy(32'h40, "x6 res x4 wr");
        expect_out(S_VAL + 0, 64'h77, "x4 rewritten");
        expect_out(S_PEND + 1, 64'h1, "x6 pending");
        step();

        // 6: reserving x0 is ignored; reset wins over a reserve.
        do_reserve(5'd0);
        step();
        idle();
        set_reads(5'd0, 5'd6);
        expect_busy(32'h40, "x0 reserve ignored");
        expect_out(S_PEND + 0, 64'h0, "x0 pend");
        step();
        reset = 1'b1;
        do_reserve(5'd9);
        step();
        idle();
        set_reads(5'd9, 5'd4);
        expect_busy(32'h0, "reset during reserve");
        expect_out(S_PEND + 0, 64'h0, "x9 pend after reset");
        expect_out(S_VAL + 1, 64'h0, "x4 after reset");
        step();

        step(); step();
        check_count++;
        if (exp_q.size() == 0) pass_count++;
        else $display("FAIL drain: got %0d unchecked expectations expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
